acc_multi_dispatcher: RTL and testbench

Issue-stage functional unit that buffers accelerator instructions from the scoreboard in an in-order queue. It releases each instruction only once the commit stage has marked it non-speculative. It routes each released instruction to one of `NrAcc` accelerator ports by opcode and merges their responses onto the single writeback port with a round-robin arbiter. It is the multi-accelerator, multi-outstanding successor of the single-slot `acc_dispatcher`.

---
 rtl/acc_multi_dispatcher_pkg.sv | 49 ++++
 rtl/acc_commit_queue.sv | 96 +++++++++
 rtl/acc_multi_dispatcher.sv | 150 +++++++++++++++
 tb/tb_acc_multi_dispatcher.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_multi_dispatcher_pkg.sv
// Shared types and constants for the multi-port accelerator dispatcher.
package acc_multi_dispatcher_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned MaxAccW       = 3;  // port index width, covers up to 8 ports

  typedef logic [XLEN-1:0] xlen_t;

  localparam xlen_t ILLEGAL_INSTR = xlen_t'(2);

  // Default major opcodes: vector extension on port 0, custom-0 on port 1
  localparam logic [6:0] OPCODE_VECTOR  = 7'b1010111;
  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    xlen_t                    operand_a;
    xlen_t                    operand_b;
    xlen_t                    imm;
  } fu_data_t;

  typedef struct packed {
    logic [31:0]              insn;
    xlen_t                    rs1;
    xlen_t                    rs2;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } accelerator_req_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    xlen_t                    result;
    logic                     error;
  } accelerator_resp_t;

  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;

  // Queue payload: instruction plus its decoded destination port
  typedef struct packed {
    fu_data_t           data;
    logic [MaxAccW-1:0] port;
    logic               nomatch;
  } acc_entry_t;

endpackage

// File: rtl/acc_commit_queue.sv
// In-order circular buffer with per-entry committed bits, id-matched commit and flush truncation.
module acc_commit_queue #(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdBits     = 3,
  parameter type         entry_t    = logic
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  entry_t                        push_data_i,
  input  logic [IdBits-1:0]             push_id_i,
  input  logic                          commit_i,
  input  logic [IdBits-1:0]             commit_id_i,
  input  logic                          pop_i,
  output logic                          head_valid_o,
  output logic                          head_committed_o,
  output entry_t                        head_data_o,
  output logic [$clog2(QueueDepth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(QueueDepth);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [QueueDepth];
  logic [IdBits-1:0] id_q  [QueueDepth];
  logic [QueueDepth-1:0] valid_q, valid_d, comm_q, comm_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       kept;

  // Next-state: commit match first, then pop, then either truncate (flush) or push
  always_comb begin
    valid_d = valid_q;
    comm_d  = comm_q;
    head_d  = head_q;
    tail_d  = tail_q;
    kept    = '0;
    if (commit_i) begin
      for (int unsigned i = 0; i < QueueDepth; i++) begin
        if (valid_q[i] && (id_q[i] == commit_id_i)) comm_d[i] = 1'b1;
      end
    end
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      comm_d[head_q]  = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (flush_i) begin
      // committed entries form a prefix, so survivors start at the new head
      for (int unsigned i = 0; i < QueueDepth; i++) begin
        valid_d[i] = valid_d[i] & comm_d[i];
        comm_d[i]  = valid_d[i];
        kept       = kept + CntW'(valid_d[i]);
      end
      tail_d = head_d + PtrW'(kept);
    end else if (push_i) begin
      valid_d[tail_q] = 1'b1;
      comm_d[tail_q]  = commit_i && (push_id_i == commit_id_i);
      tail_d          = tail_q + PtrW'(1);
    end
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      comm_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      comm_q  <= comm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload storage, qualified by the valid bits so it needs no reset
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[tail_q] <= push_data_i;
      id_q[tail_q]  <= push_id_i;
    end
  end

  // Occupancy from the valid bits
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < QueueDepth; i++) count_o = count_o + CntW'(valid_q[i]);
  end

  assign head_valid_o     = valid_q[head_q];
  assign head_committed_o = comm_q[head_q];
  assign head_data_o      = mem_q[head_q];

endmodule

// File: rtl/acc_multi_dispatcher.sv
// Buffers accelerator instructions until commit, routes them by opcode, merges responses round-robin.
module acc_multi_dispatcher
  import acc_multi_dispatcher_pkg::*;
#(
  parameter int unsigned           NrAcc      = 2,
  parameter int unsigned           QueueDepth = 4,
  parameter logic [NrAcc-1:0][6:0] AccOpcode  = {OPCODE_CUSTOM0, OPCODE_VECTOR}
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  fu_data_t                             acc_data_i,
  input  logic                                 acc_valid_i,
  output logic                                 acc_ready_o,
  input  logic                                 acc_commit_i,
  input  logic [TRANS_ID_BITS-1:0]             acc_commit_trans_id_i,
  output accelerator_req_t [NrAcc-1:0]         acc_req_o,
  output logic [NrAcc-1:0]                     acc_req_valid_o,
  input  logic [NrAcc-1:0]                     acc_req_ready_i,
  input  accelerator_resp_t [NrAcc-1:0]        acc_resp_i,
  input  logic [NrAcc-1:0]                     acc_resp_valid_i,
  output logic [NrAcc-1:0]                     acc_resp_ready_o,
  output logic [TRANS_ID_BITS-1:0]             acc_trans_id_o,
  output xlen_t                                acc_result_o,
  output logic                                 acc_valid_o,
  output exception_t                           acc_exception_o
);

  localparam int unsigned PortW = (NrAcc > 1) ? $clog2(NrAcc) : 1;
  localparam int unsigned CntW  = $clog2(QueueDepth) + 1;

  acc_entry_t          push_entry, head_entry;
  logic                push, pop, head_valid, head_committed, head_ok, local_wb;
  logic [CntW-1:0]     count;
  logic [PortW-1:0]    rr_q, rr_d, grant;
  logic                grant_valid;
  logic [2*NrAcc-1:0]  rot;
  logic                unused_imm_hi;

  assign acc_ready_o   = (count != CntW'(QueueDepth)) && !rst_i;
  assign push          = acc_valid_i && acc_ready_o;
  assign unused_imm_hi = ^head_entry.data.imm[XLEN-1:32];

  // Opcode decode at push; lowest-numbered matching port wins
  always_comb begin
    push_entry         = '0;
    push_entry.data    = acc_data_i;
    push_entry.nomatch = 1'b1;
    for (int p = NrAcc - 1; p >= 0; p--) begin
      if (acc_data_i.imm[6:0] == AccOpcode[p]) begin
        push_entry.port    = MaxAccW'(p);
        push_entry.nomatch = 1'b0;
      end
    end
  end

  acc_commit_queue #(
    .QueueDepth (QueueDepth),
    .IdBits     (TRANS_ID_BITS),
    .entry_t    (acc_entry_t)
  ) i_queue (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .push_i           (push),
    .push_data_i      (push_entry),
    .push_id_i        (acc_data_i.trans_id),
    .commit_i         (acc_commit_i),
    .commit_id_i      (acc_commit_trans_id_i),
    .pop_i            (pop),
    .head_valid_o     (head_valid),
    .head_committed_o (head_committed),
    .head_data_o      (head_entry),
    .count_o          (count)
  );

  // Head dispatch: demux valid to the decoded port, pop on its ready or on nomatch
  always_comb begin
    acc_req_valid_o = '0;
    head_ok         = head_valid && head_committed && !rst_i;
    local_wb        = head_ok && head_entry.nomatch;
    pop             = local_wb;
    for (int p = 0; p < NrAcc; p++) begin
      if (head_ok && !head_entry.nomatch && (head_entry.port == MaxAccW'(p))) begin
        acc_req_valid_o[p] = 1'b1;
        pop                = acc_req_ready_i[p];
      end
    end
  end

  // Head payload broadcast on every port
  always_comb begin
    for (int p = 0; p < NrAcc; p++) begin
      acc_req_o[p].insn     = head_entry.data.imm[31:0];
      acc_req_o[p].rs1      = head_entry.data.operand_a;
      acc_req_o[p].rs2      = head_entry.data.operand_b;
      acc_req_o[p].trans_id = head_entry.data.trans_id;
    end
  end

  // Round-robin pick: first valid response at or after the pointer
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rot         = {acc_resp_valid_i, acc_resp_valid_i} >> rr_q;
    for (int unsigned i = 0; i < NrAcc; i++) begin
      if (!grant_valid && rot[i]) begin
        grant_valid = 1'b1;
        grant       = (32'(rr_q) + i >= NrAcc) ? PortW'(32'(rr_q) + i - NrAcc)
                                               : PortW'(32'(rr_q) + i);
      end
    end
  end

  // Writeback mux: local nomatch exception beats accelerator responses
  always_comb begin
    acc_resp_ready_o = '0;
    acc_valid_o      = 1'b0;
    acc_trans_id_o   = '0;
    acc_result_o     = '0;
    acc_exception_o  = '0;
    rr_d             = rr_q;
    if (local_wb) begin
      acc_valid_o           = 1'b1;
      acc_trans_id_o        = head_entry.data.trans_id;
      acc_exception_o.cause = ILLEGAL_INSTR;
      acc_exception_o.tval  = xlen_t'(head_entry.data.imm[31:0]);
      acc_exception_o.valid = 1'b1;
    end else if (grant_valid && !rst_i) begin
      for (int p = 0; p < NrAcc; p++) begin
        if (grant == PortW'(p)) begin
          acc_resp_ready_o[p]   = 1'b1;
          acc_valid_o           = 1'b1;
          acc_trans_id_o        = acc_resp_i[p].trans_id;
          acc_result_o          = acc_resp_i[p].result;
          acc_exception_o.valid = acc_resp_i[p].error;
          acc_exception_o.cause = acc_resp_i[p].error ? ILLEGAL_INSTR : '0;
        end
      end
      rr_d = (32'(grant) == NrAcc - 1) ? '0 : grant + PortW'(1);
    end
  end

  // Arbiter pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: tb/tb_acc_multi_dispatcher.sv
// Bench for acc_multi_dispatcher: queue-based reference model plus directed scenarios.
module tb_acc_multi_dispatcher;
  import acc_multi_dispatcher_pkg::*;

  localparam int unsigned NrAcc      = 2;
  localparam int unsigned QueueDepth = 4;
  localparam logic [31:0] INS_V = 32'hABCD_E057;  // opcode 1010111 -> port 0
  localparam logic [31:0] INS_C = 32'h0000_500B;  // opcode 0001011 -> port 1
  localparam logic [31:0] INS_N = 32'h00B5_0533;  // opcode 0110011 -> no port

  logic clk = 1'b0;
  logic rst_i, flush_i, acc_valid_i, acc_ready_o, acc_commit_i, acc_valid_o;
  fu_data_t acc_data_i;
  logic [TRANS_ID_BITS-1:0] acc_commit_trans_id_i, acc_trans_id_o;
  accelerator_req_t  [NrAcc-1:0] acc_req_o;
  logic [NrAcc-1:0] acc_req_valid_o, acc_req_ready_i, acc_resp_valid_i, acc_resp_ready_o;
  accelerator_resp_t [NrAcc-1:0] acc_resp_i;
  xlen_t acc_result_o;
  exception_t acc_exception_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acc_multi_dispatcher #(.NrAcc(NrAcc), .QueueDepth(QueueDepth)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .acc_data_i(acc_data_i), .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .acc_commit_i(acc_commit_i), .acc_commit_trans_id_i(acc_commit_trans_id_i),
    .acc_req_o(acc_req_o), .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_resp_i(acc_resp_i), .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
    .acc_trans_id_o(acc_trans_id_o), .acc_result_o(acc_result_o), .acc_valid_o(acc_valid_o),
    .acc_exception_o(acc_exception_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  id;
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
    bit          c;
  } m_ent_t;

  m_ent_t     mq[$];
  int         m_ptr = 0;
  logic [2:0] disp_log[$];

  function automatic int port_of(input logic [31:0] insn);
    if (insn[6:0] == 7'b1010111) return 0;
    if (insn[6:0] == 7'b0001011) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [1:0]  e_rv, e_rr;
    logic        e_ready, e_v, e_xv;
    logic [2:0]  e_id;
    logic [63:0] e_res, e_tval, e_cause;
    int          hp, g, q;
    bit          hc, pop;
    m_ent_t      ent;
    e_rv = '0; e_rr = '0; e_v = 1'b0; e_xv = 1'b0; e_id = '0;
    e_res = '0; e_tval = '0; e_cause = '0; e_ready = 1'b0;
    hp = -1; g = -1; hc = 1'b0; pop = 1'b0;
    if (!rst_i) begin
      e_ready = (mq.size() != QueueDepth);
      if (mq.size() > 0 && mq[0].c) begin
        hc = 1'b1;
        hp = port_of(mq[0].insn);
      end
      if (hc && hp >= 0) begin
        e_rv[hp] = 1'b1;
        pop = acc_req_ready_i[hp];
      end
      if (hc && hp < 0) begin
        pop = 1'b1; e_v = 1'b1; e_id = mq[0].id; e_xv = 1'b1;
        e_cause = 64'd2; e_tval = {32'h0, mq[0].insn};
      end else begin
        for (int k = 0; k < NrAcc; k++) begin
          q = (m_ptr + k) % NrAcc;
          if (g < 0 && acc_resp_valid_i[q]) g = q;
        end
        if (g >= 0) begin
          e_rr[g] = 1'b1; e_v = 1'b1; e_id = acc_resp_i[g].trans_id;
          e_res = acc_resp_i[g].result; e_xv = acc_resp_i[g].error;
          e_cause = acc_resp_i[g].error ? 64'd2 : 64'd0;
        end
      end
    end
    chk("m_ready", acc_ready_o, e_ready);
    chk("m_req_valid", acc_req_valid_o, e_rv);
    chk("m_resp_ready", acc_resp_ready_o, e_rr);
    chk("m_wb_valid", acc_valid_o, e_v);
    chk("m_exc_valid", acc_exception_o.valid, e_xv);
    chk("m_exc_cause", acc_exception_o.cause, e_cause);
    chk("m_exc_tval", acc_exception_o.tval, e_tval);
    if (e_v) begin
      chk("m_wb_id", acc_trans_id_o, e_id);
      chk("m_wb_result", acc_result_o, e_res);
    end
    if (e_rv != 0) begin
      chk("m_req_insn", acc_req_o[hp].insn, mq[0].insn);
      chk("m_req_rs1", acc_req_o[hp].rs1, mq[0].rs1);
      chk("m_req_rs2", acc_req_o[hp].rs2, mq[0].rs2);
      chk("m_req_id", acc_req_o[hp].trans_id, mq[0].id);
    end
    for (int p = 0; p < NrAcc; p++)
      if (acc_req_valid_o[p] && acc_req_ready_i[p]) disp_log.push_back(acc_req_o[p].trans_id);
    if (rst_i) begin
      mq.delete();
      m_ptr = 0;
    end else begin
      if (acc_commit_i)
        foreach (mq[i]) if (mq[i].id == acc_commit_trans_id_i) mq[i].c = 1'b1;
      if (pop) void'(mq.pop_front());
      if (flush_i) begin
        while (mq.size() > 0 && !mq[mq.size()-1].c) void'(mq.pop_back());
      end else if (acc_valid_i && e_ready) begin
        ent.id   = acc_data_i.trans_id;
        ent.insn = acc_data_i.imm[31:0];
        ent.rs1  = acc_data_i.operand_a;
        ent.rs2  = acc_data_i.operand_b;
        ent.c    = acc_commit_i && (acc_commit_trans_id_i == acc_data_i.trans_id);
        mq.push_back(ent);
      end
      if (g >= 0) m_ptr = (g + 1) % NrAcc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    acc_valid_i = 1'b0; acc_commit_i = 1'b0; flush_i = 1'b0;
    acc_data_i = '0; acc_commit_trans_id_i = '0;
  endtask

  task automatic push(input logic [2:0] id, input logic [31:0] insn, input bit cm);
    acc_valid_i = 1'b1;
    acc_data_i = '0;
    acc_data_i.trans_id  = id;
    acc_data_i.imm       = {32'h0, insn};
    acc_data_i.operand_a = 64'h1000 + 64'(id);
    acc_data_i.operand_b = 64'h2000 + 64'(id);
    if (cm) begin
      acc_commit_i = 1'b1;
      acc_commit_trans_id_i = id;
    end
  endtask

  task automatic commit(input logic [2:0] id);
    acc_commit_i = 1'b1;
    acc_commit_trans_id_i = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    acc_req_ready_i = '0; acc_resp_valid_i = '0; acc_resp_i = '0; rst_i = 1'b1;
    cyc(); cyc();
    chk("rst_ready", acc_ready_o, 0);
    chk("rst_req_valid", acc_req_valid_o, 0);
    chk("rst_wb_valid", acc_valid_o, 0);
    cyc(); rst_i = 1'b0; #1;
    chk("post_rst_ready", acc_ready_o, 1);

    // Commit gating: dispatch only the cycle after the commit
    cyc(); idle(); push(3, INS_V, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); idle(); if (k == 4) commit(3); #1;
      chk("t1_gated", acc_req_valid_o, 0);
    end
    cyc(); idle(); #1;
    chk("t1_valid", acc_req_valid_o, 2'b01);
    chk("t1_insn", acc_req_o[0].insn, 32'hABCD_E057);
    chk("t1_rs1", acc_req_o[0].rs1, 64'h1003);
    chk("t1_rs2", acc_req_o[0].rs2, 64'h2003);
    acc_req_ready_i = 2'b01;
    cyc(); idle(); #1;
    chk("t1_popped", acc_req_valid_o, 0);

    // Routing with in-order stall on port 1
    disp_log.delete();
    cyc(); idle(); push(1, INS_C, 1);
    cyc(); idle(); push(2, INS_V, 1); #1;
    chk("t2_stall_a", acc_req_valid_o, 2'b10);
    chk("t2_stall_id", acc_req_o[1].trans_id, 1);
    cyc(); idle(); #1; chk("t2_stall_b", acc_req_valid_o, 2'b10);
    cyc(); idle(); #1; chk("t2_stall_c", acc_req_valid_o, 2'b10);
    acc_req_ready_i = 2'b11;
    cyc(); idle(); #1;
    chk("t2_second", acc_req_valid_o, 2'b01);
    chk("t2_second_id", acc_req_o[0].trans_id, 2);
    cyc(); idle(); #1;
    chk("t2_log_n", disp_log.size(), 2);
    chk("t2_log_0", disp_log[0], 1);
    chk("t2_log_1", disp_log[1], 2);
    acc_req_ready_i = '0;

    // Full queue, then a pop frees a slot one cycle later
    disp_log.delete();
    for (int id = 0; id < 4; id++) begin
      cyc(); idle(); push(3'(id), INS_V, 0);
    end
    cyc(); idle(); push(7, INS_V, 0); #1;
    chk("t3_full", acc_ready_o, 0);
    cyc(); idle(); commit(0); acc_req_ready_i = 2'b01; #1;
    chk("t3_full_commit", acc_ready_o, 0);
    cyc(); idle(); #1;
    chk("t3_disp", acc_req_valid_o, 2'b01);
    chk("t3_full_pop", acc_ready_o, 0);
    cyc(); idle(); commit(1); #1;
    chk("t3_ready_after_pop", acc_ready_o, 1);
    cyc(); idle(); commit(2);
    cyc(); idle(); commit(3);
    repeat (3) begin cyc(); idle(); end
    #1;
    chk("t3_log_n", disp_log.size(), 4);
    chk("t3_log_3", disp_log[3], 3);
    acc_req_ready_i = '0;

    // Flush keeps the committed prefix only
    disp_log.delete();
    cyc(); idle(); push(0, INS_V, 1);
    cyc(); idle(); push(1, INS_V, 1);
    cyc(); idle(); push(2, INS_V, 0);
    cyc(); idle(); push(3, INS_V, 0);
    cyc(); idle(); flush_i = 1'b1; #1;
    chk("t4_head_kept", acc_req_valid_o, 2'b01);
    cyc(); idle(); acc_req_ready_i = 2'b01;
    repeat (3) begin cyc(); idle(); end
    #1;
    chk("t4_log_n", disp_log.size(), 2);
    chk("t4_log_0", disp_log[0], 0);
    chk("t4_log_1", disp_log[1], 1);
    chk("t4_empty", acc_req_valid_o, 0);
    cyc(); idle(); commit(2);
    cyc(); idle(); #1;
    chk("t4_nothing_left", acc_req_valid_o, 0);
    acc_req_ready_i = '0;

    // Round-robin arbitration over two persistent responses
    cyc(); idle();
    acc_resp_i[0].trans_id = 3'd4; acc_resp_i[0].result = 64'hAAAA; acc_resp_i[0].error = 1'b0;
    acc_resp_i[1].trans_id = 3'd6; acc_resp_i[1].result = 64'hBBBB; acc_resp_i[1].error = 1'b1;
    acc_resp_valid_i = 2'b11; #1;
    chk("t5_g0", acc_resp_ready_o, 2'b01);
    chk("t5_g0_id", acc_trans_id_o, 4);
    chk("t5_g0_exc", acc_exception_o.valid, 0);
    cyc(); #1;
    chk("t5_g1", acc_resp_ready_o, 2'b10);
    chk("t5_g1_res", acc_result_o, 64'hBBBB);
    chk("t5_g1_exc", acc_exception_o.valid, 1);
    chk("t5_g1_cause", acc_exception_o.cause, 64'd2);
    cyc(); #1; chk("t5_g2", acc_resp_ready_o, 2'b01);
    cyc(); #1; chk("t5_g3", acc_resp_ready_o, 2'b10);
    cyc(); acc_resp_valid_i = '0;

    // Unmatched opcode: local exception writeback stalls responses
    cyc(); idle(); push(5, INS_N, 1);
    cyc(); idle(); acc_resp_valid_i = 2'b11; #1;
    chk("t6_valid", acc_valid_o, 1);
    chk("t6_id", acc_trans_id_o, 5);
    chk("t6_exc", acc_exception_o.valid, 1);
    chk("t6_tval", acc_exception_o.tval, 64'h00B5_0533);
    chk("t6_stalled", acc_resp_ready_o, 2'b00);
    cyc(); idle(); #1;
    chk("t6_resume", acc_resp_ready_o, 2'b01);
    chk("t6_resume_id", acc_trans_id_o, 4);
    cyc(); acc_resp_valid_i = '0;

    // Back-to-back dispatch with ready held high
    disp_log.delete();
    acc_req_ready_i = 2'b11;
    for (int id = 0; id < 4; id++) begin
      cyc(); idle(); push(3'(id), (id == 2) ? INS_C : INS_V, 1);
    end
    cyc(); idle(); #1;
    chk("t7_last", acc_req_valid_o, 2'b01);
    cyc(); idle(); #1;
    chk("t7_log_n", disp_log.size(), 4);

    // Reset mid-operation; a response after reset is still forwarded
    acc_req_ready_i = '0;
    cyc(); idle(); push(1, INS_V, 1);
    cyc(); idle(); push(2, INS_V, 0);
    cyc(); idle(); rst_i = 1'b1; acc_resp_valid_i = 2'b01; #1;
    chk("t8_rst_ready", acc_ready_o, 0);
    chk("t8_rst_req", acc_req_valid_o, 0);
    chk("t8_rst_resp", acc_resp_ready_o, 0);
    cyc(); rst_i = 1'b0; #1;
    chk("t8_post_req", acc_req_valid_o, 0);
    chk("t8_post_resp", acc_resp_ready_o, 2'b01);

    // Push during a flush is dropped
    cyc(); idle(); acc_resp_valid_i = '0; push(6, INS_V, 1); flush_i = 1'b1;
    cyc(); idle(); #1;
    chk("t9_dropped", acc_req_valid_o, 0);

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
